alu_activity_monitor: RTL and testbench

ALU_ACTIVITY_MONITOR -- requirements
Module: alu_activity_monitor

---
 rtl/alu_mon_pkg.sv | 31 +++
 rtl/alu_golden_model.sv | 54 +++++
 rtl/alu_activity_monitor.sv | 176 +++++++++++++++++
 tb/tb_alu_activity_monitor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mon_pkg.sv
// Shared definitions for the ALU activity monitor.
//   - RESP_W       : width of the ALU response vector {result,carry,zero,overflow}
//   - OP_*         : ALU opcode encodings used by the golden model
//   - mon_state_e  : monitor FSM states
//   - popcount7()  : bit count of a response-vector difference
package alu_mon_pkg;

    localparam int RESP_W = 7;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mon_state_e;

    // Number of set bits in a 7-bit vector (Hamming weight).
    function automatic logic [2:0] popcount7(input logic [RESP_W-1:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < RESP_W; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference 4-bit ALU.
// Ports:
//   a, b  : 4-bit operands
//   op    : opcode (ADD/SUB/AND/OR from alu_mon_pkg)
//   resp  : expected {result[3:0], carry, zero, overflow}
// SUB carry is the inverted borrow (1 = no borrow), produced as A + ~B + 1.
module alu_golden_model
    import alu_mon_pkg::*;
(
    input  logic [3:0]        a,
    input  logic [3:0]        b,
    input  logic [1:0]        op,
    output logic [RESP_W-1:0] resp
);

    logic [4:0] sum_s;
    logic [3:0] res_s;
    logic       carry_s;
    logic       ovf_s;

    // Reference ALU datapath.
    always_comb begin
        sum_s   = 5'd0;
        res_s   = 4'd0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op)
            OP_ADD: begin
                sum_s   = {1'b0, a} + {1'b0, b};
                res_s   = sum_s[3:0];
                carry_s = sum_s[4];
                ovf_s   = (a[3] == b[3]) && (sum_s[3] != a[3]);
            end
            OP_SUB: begin
                sum_s   = {1'b0, a} + {1'b0, ~b} + 5'd1;
                res_s   = sum_s[3:0];
                carry_s = sum_s[4];
                ovf_s   = (a[3] != b[3]) && (sum_s[3] != a[3]);
            end
            OP_AND: begin
                res_s = a & b;
            end
            OP_OR: begin
                res_s = a | b;
            end
            default: begin
                res_s = 4'd0;
            end
        endcase
    end

    assign resp = {res_s, carry_s, (res_s == 4'd0), ovf_s};

endmodule

// File: rtl/alu_activity_monitor.sv
// Captures a window of WINDOW accepted ALU samples, accumulating the Hamming
// distance between consecutive response vectors and (optionally) counting
// responses that disagree with a golden model. At the end of the window a
// one-cycle done pulse is issued together with a held anomaly verdict.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start                 : begin a window (only honoured in IDLE)
//   sample_valid          : sample A/B/op and the response this cycle (RUN only)
//   A, B, op              : ALU stimulus
//   result, carry, zero, overflow : ALU response under test
//   busy, done            : RUN indicator, end-of-window pulse
//   toggle_count          : saturating toggle accumulator
//   mismatch_count        : saturating golden-compare failure count
//   first_mismatch_vec/_valid : {A,B,op} of the first failing sample
//   anomaly               : window verdict, held until the next start
// Build option: ALU_MON_GOLDEN_EN enables the golden comparison; without it the
// mismatch outputs stay 0 and anomaly reflects the toggle threshold only.
module alu_activity_monitor
    import alu_mon_pkg::*;
#(
    parameter int unsigned  WINDOW        = 1024,
    parameter logic [15:0]  TOGGLE_THRESH = 16'd2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sample_valid,
    input  logic [3:0]  A,
    input  logic [3:0]  B,
    input  logic [1:0]  op,
    input  logic [3:0]  result,
    input  logic        carry,
    input  logic        zero,
    input  logic        overflow,
    output logic        busy,
    output logic        done,
    output logic [15:0] toggle_count,
    output logic [11:0] mismatch_count,
    output logic [9:0]  first_mismatch_vec,
    output logic        first_mismatch_valid,
    output logic        anomaly
);

    localparam logic [15:0] WINDOW_M1 = 16'(WINDOW - 1);

    mon_state_e         state_r;
    logic               busy_r;
    logic               done_r;
    logic [15:0]        toggle_count_r;
    logic [11:0]        mismatch_count_r;
    logic [9:0]         fm_vec_r;
    logic               fm_valid_r;
    logic               anomaly_r;
    logic [15:0]        sample_cnt_r;
    logic [RESP_W-1:0]  prev_vec_r;

    logic [RESP_W-1:0]  resp_s;
    logic [RESP_W-1:0]  golden_s;
    logic               mismatch_s;
    logic [16:0]        toggle_sum_s;
    logic [15:0]        toggle_next_s;
    logic [11:0]        mismatch_next_s;

    assign resp_s = {result, carry, zero, overflow};

    alu_golden_model u_golden (
        .a    (A),
        .b    (B),
        .op   (op),
        .resp (golden_s)
    );

`ifdef ALU_MON_GOLDEN_EN
    assign mismatch_s = (golden_s != resp_s);
`else
    logic unused_golden_s;
    assign unused_golden_s = ^golden_s;
    assign mismatch_s      = 1'b0;
`endif

    // Next values of the saturating accumulators for an accepted sample.
    always_comb begin
        toggle_sum_s    = {1'b0, toggle_count_r} + {14'd0, popcount7(resp_s ^ prev_vec_r)};
        toggle_next_s   = toggle_count_r;
        mismatch_next_s = mismatch_count_r;
        // The first sample of a window has no predecessor to toggle against.
        if (sample_cnt_r == 16'd0) begin
            toggle_next_s = toggle_count_r;
        end else if (toggle_sum_s[16]) begin
            toggle_next_s = 16'hFFFF;
        end else begin
            toggle_next_s = toggle_sum_s[15:0];
        end
        if (!mismatch_s) begin
            mismatch_next_s = mismatch_count_r;
        end else if (mismatch_count_r == 12'hFFF) begin
            mismatch_next_s = 12'hFFF;
        end else begin
            mismatch_next_s = mismatch_count_r + 12'd1;
        end
    end

    // Monitor FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            toggle_count_r   <= 16'd0;
            mismatch_count_r <= 12'd0;
            fm_vec_r         <= 10'd0;
            fm_valid_r       <= 1'b0;
            anomaly_r        <= 1'b0;
            sample_cnt_r     <= 16'd0;
            prev_vec_r       <= {RESP_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r          <= ST_RUN;
                        busy_r           <= 1'b1;
                        toggle_count_r   <= 16'd0;
                        mismatch_count_r <= 12'd0;
                        fm_valid_r       <= 1'b0;
                        anomaly_r        <= 1'b0;
                        sample_cnt_r     <= 16'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (sample_valid) begin
                        toggle_count_r   <= toggle_next_s;
                        mismatch_count_r <= mismatch_next_s;
                        prev_vec_r       <= resp_s;
                        sample_cnt_r     <= sample_cnt_r + 16'd1;
                        if (mismatch_s && !fm_valid_r) begin
                            fm_vec_r   <= {A, B, op};
                            fm_valid_r <= 1'b1;
                        end else begin
                            fm_valid_r <= fm_valid_r;
                        end
                        // The sample that completes the window is fully counted above.
                        if (sample_cnt_r == WINDOW_M1) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    done_r    <= 1'b1;
                    anomaly_r <= (mismatch_count_r != 12'd0) || (toggle_count_r > TOGGLE_THRESH);
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy                 = busy_r;
    assign done                 = done_r;
    assign toggle_count         = toggle_count_r;
    assign mismatch_count       = mismatch_count_r;
    assign first_mismatch_vec   = fm_vec_r;
    assign first_mismatch_valid = fm_valid_r;
    assign anomaly              = anomaly_r;

endmodule

// File: tb/tb_alu_activity_monitor.sv
// Self-checking bench for alu_activity_monitor (WINDOW=4, TOGGLE_THRESH=10).
// A behavioural model tracks the expected window results from the monitor's
// rules using integer arithmetic; mismatch expectations follow the
// ALU_MON_GOLDEN_EN build option.
module tb_alu_activity_monitor;

    localparam int          WIN    = 4;
    localparam logic [15:0] THRESH = 16'd10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sample_valid;
    logic [3:0]  A;
    logic [3:0]  B;
    logic [1:0]  op;
    logic [3:0]  result;
    logic        carry;
    logic        zero;
    logic        overflow;
    logic        busy;
    logic        done;
    logic [15:0] toggle_count;
    logic [11:0] mismatch_count;
    logic [9:0]  first_mismatch_vec;
    logic        first_mismatch_valid;
    logic        anomaly;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    bit          m_run;
    int          m_count;
    int          m_toggle;
    int          m_mism;
    bit          m_fmv;
    logic [9:0]  m_fmvec;
    logic [6:0]  m_prev;
    bit          m_anom;

    alu_activity_monitor #(.WINDOW(WIN), .TOGGLE_THRESH(THRESH)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .sample_valid         (sample_valid),
        .A                    (A),
        .B                    (B),
        .op                   (op),
        .result               (result),
        .carry                (carry),
        .zero                 (zero),
        .overflow             (overflow),
        .busy                 (busy),
        .done                 (done),
        .toggle_count         (toggle_count),
        .mismatch_count       (mismatch_count),
        .first_mismatch_vec   (first_mismatch_vec),
        .first_mismatch_valid (first_mismatch_valid),
        .anomaly              (anomaly)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected ALU response from plain integer arithmetic.
    function automatic logic [6:0] gold(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o);
        int ua, ub, sa, sb, u, sr;
        logic [3:0] r;
        logic c, ov;
        ua = a; ub = b;
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        u = 0; sr = 0;
        case (o)
            2'd0: begin u = ua + ub;            sr = sa + sb; end
            2'd1: begin u = ua + (15 - ub) + 1; sr = sa - sb; end
            2'd2: u = ua & ub;
            default: u = ua | ub;
        endcase
        r  = u[3:0];
        c  = (o < 2'd2) && (u >= 16);
        ov = (o < 2'd2) && (sr > 7 || sr < -8);
        return {r, c, (r == 4'd0), ov};
    endfunction

    // Drive one cycle of stimulus and advance the model if the sample is accepted.
    task automatic drive(input bit v, input bit st, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] o, input logic [6:0] resp);
        sample_valid = v; start = st;
        A = a; B = b; op = o;
        {result, carry, zero, overflow} = resp;
        if (v && m_run) begin
            if (m_count > 0) begin
                m_toggle = m_toggle + $countones(resp ^ m_prev);
                if (m_toggle > 65535) m_toggle = 65535;
            end
`ifdef ALU_MON_GOLDEN_EN
            if (resp != gold(a, b, o)) begin
                if (m_mism < 4095) m_mism++;
                if (!m_fmv) begin
                    m_fmv = 1'b1;
                    m_fmvec = {a, b, o};
                end
            end
`endif
            m_prev = resp;
            m_count++;
            if (m_count == WIN) begin
                m_run  = 1'b0;
                m_anom = (m_mism != 0) || (m_toggle > int'(THRESH));
            end
        end
        @(negedge clk);
        sample_valid = 1'b0; start = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_run = 1'b1; m_count = 0; m_toggle = 0; m_mism = 0; m_fmv = 1'b0; m_anom = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_toggle_clr", toggle_count, 0);
        check_eq("start_mism_clr", mismatch_count, 0);
        check_eq("start_fmv_clr", first_mismatch_valid, 0);
        check_eq("start_anom_clr", anomaly, 0);
    endtask

    task automatic check_results(input string tag);
        check_eq({tag, "_toggle"}, toggle_count, m_toggle);
        check_eq({tag, "_mism"}, mismatch_count, m_mism);
        check_eq({tag, "_fmv"}, first_mismatch_valid, m_fmv);
        if (m_fmv) check_eq({tag, "_fmvec"}, first_mismatch_vec, m_fmvec);
        else       check_eq({tag, "_fmv_off"}, first_mismatch_valid, 0);
    endtask

    // Called on the negedge right after the last sample was accepted.
    task automatic end_window(input string tag);
        check_eq({tag, "_done_early"}, done, 0);
        check_eq({tag, "_busy_off"}, busy, 0);
        @(negedge clk);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_anomaly"}, anomaly, m_anom);
        check_results(tag);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_anom_hold"}, anomaly, m_anom);
        check_results({tag, "_hold"});
    endtask

    initial begin
        int guard;
        logic [3:0] ra, rb;
        logic [1:0] ro;
        logic [6:0] rr;

        rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0;
        A = 4'd0; B = 4'd0; op = 2'd0;
        result = 4'd0; carry = 1'b0; zero = 1'b0; overflow = 1'b0;
        m_run = 1'b0; m_count = 0; m_toggle = 0; m_mism = 0; m_fmv = 1'b0; m_fmvec = 10'd0;
        m_prev = 7'd0; m_anom = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_toggle", toggle_count, 0);
        check_eq("rst_mism", mismatch_count, 0);
        check_eq("rst_fmvec", first_mismatch_vec, 0);
        check_eq("rst_fmv", first_mismatch_valid, 0);
        check_eq("rst_anom", anomaly, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Matching ADD, then a SUB with a corrupted result.
        do_start();
        drive(1'b1, 1'b0, 4'd7, 4'd1, 2'b00, 7'b1000_001);
        check_eq("add_match_gold", gold(4'd7, 4'd1, 2'b00), 7'b1000_001);
        check_eq("add_match_mism", mismatch_count, 0);
        drive(1'b1, 1'b0, 4'd3, 4'd3, 2'b01, {4'd1, 1'b1, 1'b0, 1'b0});
        check_results("sub_bad");
`ifdef ALU_MON_GOLDEN_EN
        check_eq("sub_bad_fmvec_lit", first_mismatch_vec, 10'b0011_0011_01);
`else
        check_eq("nogold_mism_zero", mismatch_count, 0);
`endif
        drive(1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 7'h00);
        drive(1'b1, 1'b0, 4'd2, 4'd5, 2'b11, gold(4'd2, 4'd5, 2'b11));
        drive(1'b1, 1'b0, 4'd9, 4'd4, 2'b10, gold(4'd9, 4'd4, 2'b10));
        end_window("w1");

        // Toggle scenario: 0x00, 0x7F, 0x00, 0x01 -> 15 toggles, above threshold.
        do_start();
        drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b10, 7'h00);
        drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b10, 7'h7F);
        drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b10, 7'h00);
        drive(1'b1, 1'b0, 4'd0, 4'd0, 2'b10, 7'h01);
        end_window("tog");
        check_eq("tog_lit15", toggle_count, 16'd15);
        check_eq("tog_anom_lit", anomaly, 1);
        // Samples outside RUN are ignored and results stay held.
        repeat (3) drive(1'b1, 1'b0, 4'd15, 4'd15, 2'b00, 7'h55);
        check_eq("idle_hold_toggle", toggle_count, 16'd15);
        check_eq("idle_hold_anom", anomaly, 1);

        // start during RUN must not clear counters.
        do_start();
        drive(1'b1, 1'b0, 4'd1, 4'd2, 2'b00, 7'h3C);
        drive(1'b1, 1'b0, 4'd1, 4'd2, 2'b00, 7'h03);
        drive(1'b0, 1'b1, 4'd0, 4'd0, 2'b00, 7'h00);
        check_eq("run_start_busy", busy, 1);
        check_results("run_start");
        drive(1'b1, 1'b1, 4'd4, 4'd4, 2'b01, 7'h12);
        drive(1'b1, 1'b0, 4'd8, 4'd8, 2'b00, 7'h60);
        end_window("w3");

        // Randomized windows with gaps, corrupted responses and stray starts.
        for (int w = 0; w < 20; w++) begin
            do_start();
            guard = 0;
            while (m_run && guard < 100) begin
                ra = 4'($urandom); rb = 4'($urandom); ro = 2'($urandom);
                rr = gold(ra, rb, ro);
                if ($urandom_range(0, 1) == 0) rr = 7'($urandom);
                drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), ra, rb, ro, rr);
                guard++;
            end
            check_eq("rand_timeout", guard < 100, 1);
            end_window("rand");
        end

        // Reset pulse in the middle of a window.
        do_start();
        drive(1'b1, 1'b0, 4'd3, 4'd3, 2'b01, 7'h7F);
        drive(1'b1, 1'b0, 4'd3, 4'd3, 2'b01, 7'h00);
        rst_n = 1'b0;
        #1;
        m_run = 1'b0;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_toggle", toggle_count, 0);
        check_eq("mid_rst_mism", mismatch_count, 0);
        check_eq("mid_rst_fmvec", first_mismatch_vec, 0);
        check_eq("mid_rst_fmv", first_mismatch_valid, 0);
        check_eq("mid_rst_anom", anomaly, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // In IDLE: samples ignored, no busy until a new start.
        drive(1'b1, 1'b0, 4'd1, 4'd1, 2'b00, 7'h00);
        drive(1'b1, 1'b0, 4'd1, 4'd1, 2'b00, 7'h7F);
        check_eq("post_rst_idle_busy", busy, 0);
        check_eq("post_rst_idle_toggle", toggle_count, 0);
        do_start();
        for (int i = 0; i < WIN; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); ro = 2'($urandom);
            drive(1'b1, 1'b0, ra, rb, ro, gold(ra, rb, ro));
        end
        end_window("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
